// File: rtl/pay_pkg.sv
// Shared types and helpers for the coin-entry / payment-settlement controller.
// Holds the FSM state enum, coin values, the two-digit BCD type and BCD helpers.
// Ports: none (package).
package pay_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PAID    = 2'd2,
        ST_EXPIRED = 2'd3
    } pay_state_t;

    localparam logic [4:0] COIN1_VAL  = 5'd1;
    localparam logic [4:0] COIN5_VAL  = 5'd5;
    localparam logic [4:0] COIN10_VAL = 5'd10;

    localparam int DEFAULT_TIMEOUT_S = 30;

    // Two BCD digits; tens in the upper nibble so a plain vector compare
    // orders valid BCD values numerically.
    typedef struct packed {
        logic [3:0] ten;
        logic [3:0] one;
    } bcd2_t;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    // Adds 0..16 to a BCD value, digit-wise with carry, saturating at 99.
    function automatic bcd2_t bcd_add_sat(input bcd2_t a, input logic [4:0] add);
        logic       add_ten;
        logic [4:0] add_one;
        logic [4:0] one_sum;
        logic [4:0] ten_sum;
        logic       carry;
        bcd2_t      r;
        add_ten = (add >= 5'd10);
        add_one = add_ten ? (add - 5'd10) : add;
        one_sum = {1'b0, a.one} + add_one;
        carry   = (one_sum > 5'd9);
        if (carry) begin
            one_sum = one_sum - 5'd10;
        end
        ten_sum = {1'b0, a.ten} + {4'd0, add_ten} + {4'd0, carry};
        if (ten_sum > 5'd9) begin
            r.ten = 4'd9;
            r.one = 4'd9;
        end else begin
            r.ten = ten_sum[3:0];
            r.one = one_sum[3:0];
        end
        return r;
    endfunction

    // a - b digit-wise with borrow; callers guarantee a >= b.
    function automatic bcd2_t bcd_sub(input bcd2_t a, input bcd2_t b);
        logic  borrow;
        bcd2_t r;
        borrow = (a.one < b.one);
        r.one  = borrow ? (a.one + 4'd10 - b.one) : (a.one - b.one);
        r.ten  = a.ten - b.ten - {3'd0, borrow};
        return r;
    endfunction

endpackage

// File: rtl/coin_filter.sv
// Conditions one raw coin button: 2-FF synchronizer, optional debounce
// (PAY_DEBOUNCE_EN), and a registered one-cycle rising-edge pulse.
// Ports: clk, rst (sync, active-high), raw (async level), pulse (1-cycle edge).
module coin_filter
    import pay_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic level;
    logic level_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

`ifdef PAY_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CNT_W-1:0] cnt;

    // The filtered level follows only after the new level has been seen on
    // DEBOUNCE_CYCLES consecutive samples; any bounce back restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync2 != level) begin
            if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end
`else
    assign level = sync2;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            level_d <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            level_d <= level;
            pulse   <= level & ~level_d;
        end
    end

endmodule

// File: rtl/pay_collect.sv
// Payment controller: latches a BCD cost, accumulates coins, runs a timed window,
// settles to PAID (change) or EXPIRED (refund) and waits for ack. Optional
// coin debounce is compiled in with PAY_DEBOUNCE_EN.
// Ports: clk, rst, start, ack, cost digits, raw coins in; BCD paid/change/secs
// and busy/paid_ok/expired flags out, all registered.
module pay_collect
    import pay_pkg::*;
#(
    parameter int TICKS_PER_SEC   = 100_000_000,
    parameter int TIMEOUT_S       = DEFAULT_TIMEOUT_S,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       ack,
    input  logic [3:0] costone,
    input  logic [3:0] costten,
    input  logic       coin1,
    input  logic       coin5,
    input  logic       coin10,
    output logic [3:0] paidone,
    output logic [3:0] paidten,
    output logic [3:0] changeone,
    output logic [3:0] changeten,
    output logic [3:0] secsone,
    output logic [3:0] secsten,
    output logic       busy,
    output logic       paid_ok,
    output logic       expired
);

    localparam int    TICK_W      = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam bcd2_t TIMEOUT_BCD = '{ten: 4'(TIMEOUT_S / 10), one: 4'(TIMEOUT_S % 10)};
    localparam bcd2_t BCD_ONE     = '{ten: 4'd0, one: 4'd1};

    pay_state_t        state;
    bcd2_t             cost;
    bcd2_t             paid;
    bcd2_t             change;
    bcd2_t             secs;
    logic [TICK_W-1:0] tick;

    logic       p1;
    logic       p5;
    logic       p10;
    logic [4:0] coin_sum;

    coin_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_coin1 (
        .clk(clk), .rst(rst), .raw(coin1), .pulse(p1)
    );
    coin_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_coin5 (
        .clk(clk), .rst(rst), .raw(coin5), .pulse(p5)
    );
    coin_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_coin10 (
        .clk(clk), .rst(rst), .raw(coin10), .pulse(p10)
    );

    // Edges landing in the same cycle are credited together (at most 16).
    assign coin_sum = (p1  ? COIN1_VAL  : 5'd0)
                    + (p5  ? COIN5_VAL  : 5'd0)
                    + (p10 ? COIN10_VAL : 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cost    <= '0;
            paid    <= '0;
            change  <= '0;
            secs    <= TIMEOUT_BCD;
            tick    <= '0;
            busy    <= 1'b0;
            paid_ok <= 1'b0;
            expired <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cost    <= '{ten: bcd_clamp(costten), one: bcd_clamp(costone)};
                        paid    <= '0;
                        change  <= '0;
                        secs    <= TIMEOUT_BCD;
                        tick    <= '0;
                        state   <= ST_COLLECT;
                        busy    <= 1'b1;
                    end
                end
                ST_COLLECT: begin
                    // Settlement looks at the registered total, so payment is
                    // tested ahead of expiry and wins a same-cycle tie.
                    if (paid >= cost) begin
                        change  <= bcd_sub(paid, cost);
                        state   <= ST_PAID;
                        busy    <= 1'b0;
                        paid_ok <= 1'b1;
                    end else if (secs == '0) begin
                        change  <= paid;
                        state   <= ST_EXPIRED;
                        busy    <= 1'b0;
                        expired <= 1'b1;
                    end else begin
                        if (coin_sum != 5'd0) begin
                            paid <= bcd_add_sat(paid, coin_sum);
                        end
                        if (tick == TICK_W'(TICKS_PER_SEC - 1)) begin
                            tick <= '0;
                            secs <= bcd_sub(secs, BCD_ONE);
                        end else begin
                            tick <= tick + 1'b1;
                        end
                    end
                end
                ST_PAID, ST_EXPIRED: begin
                    if (ack) begin
                        state   <= ST_IDLE;
                        paid_ok <= 1'b0;
                        expired <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign paidone   = paid.one;
    assign paidten   = paid.ten;
    assign changeone = change.one;
    assign changeten = change.ten;
    assign secsone   = secs.one;
    assign secsten   = secs.ten;

endmodule

// File: tb/tb_pay_collect.sv
// Scoreboard bench for pay_collect: a decimal-arithmetic model predicts every
// visible output change; a monitor pops and compares whenever outputs move.
// Ports: none (top-level bench).
module tb_pay_collect;

    localparam int TPS = 10;
    localparam int TOS = 30;
    localparam int DEB = 4;
`ifdef PAY_DEBOUNCE_EN
    localparam int DEB_LAT       = DEB;
    localparam bit GLITCH_COUNTS = 1'b0;
`else
    localparam int DEB_LAT       = 0;
    localparam bit GLITCH_COUNTS = 1'b1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       ack = 1'b0;
    logic [3:0] costone = 4'd0;
    logic [3:0] costten = 4'd0;
    logic       coin1 = 1'b0;
    logic       coin5 = 1'b0;
    logic       coin10 = 1'b0;
    logic [3:0] paidone, paidten, changeone, changeten, secsone, secsten;
    logic       busy, paid_ok, expired;

    pay_collect #(.TICKS_PER_SEC(TPS), .TIMEOUT_S(TOS), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk), .rst(rst), .start(start), .ack(ack),
        .costone(costone), .costten(costten),
        .coin1(coin1), .coin5(coin5), .coin10(coin10),
        .paidone(paidone), .paidten(paidten),
        .changeone(changeone), .changeten(changeten),
        .secsone(secsone), .secsten(secsten),
        .busy(busy), .paid_ok(paid_ok), .expired(expired)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: plain decimal amounts and a transaction phase.
    localparam int M_IDLE = 0, M_COLLECT = 1, M_PAID = 2, M_EXPIRED = 3;
    int m_state = M_IDLE;
    int m_cost  = 0;
    int m_paid  = 0;
    int m_chg   = 0;

    logic [18:0] exp_q[$];
    bit          mon_en = 1'b0;
    logic [18:0] prev_rec;

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [18:0] mk(input int p, input int c, input bit b, input bit o, input bit e);
        return {bcd(p), bcd(c), b, o, e};
    endfunction

    function automatic logic [18:0] rec();
        return {paidten, paidone, changeten, changeone, busy, paid_ok, expired};
    endfunction

    task automatic check(input string name, input int actual, input int required);
        tests++;
        if (actual != required) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, required);
        end
    endtask

    // Monitor: every change of the paid/change/flag record consumes one prediction.
    initial begin
        logic [18:0] cur;
        logic [18:0] e;
        forever begin
            @(negedge clk);
            cur = rec();
            if (mon_en && (cur !== prev_rec)) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_output: got %h, nothing predicted", cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        fails++;
                        $display("FAIL output_record: got %h, expected %h", cur, e);
                    end
                end
            end
            prev_rec = cur;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d predicted changes not seen in %0d cycles", exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic do_start(input int ct, input int co);
        m_cost  = ((ct > 9) ? 9 : ct) * 10 + ((co > 9) ? 9 : co);
        m_paid  = 0;
        m_chg   = 0;
        m_state = M_COLLECT;
        exp_q.push_back(mk(0, 0, 1, 0, 0));
        if (m_cost == 0) begin
            m_state = M_PAID;
            exp_q.push_back(mk(0, 0, 0, 1, 0));
        end
        costten = 4'(ct);
        costone = 4'(co);
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic m_coin(input logic [2:0] mask, input bit eff);
        int sum;
        int nv;
        if (m_state != M_COLLECT || !eff) return;
        sum = (mask[0] ? 1 : 0) + (mask[1] ? 5 : 0) + (mask[2] ? 10 : 0);
        nv  = (m_paid + sum > 99) ? 99 : m_paid + sum;
        if (nv != m_paid) exp_q.push_back(mk(nv, 0, 1, 0, 0));
        m_paid = nv;
        if (m_paid >= m_cost) begin
            m_chg   = m_paid - m_cost;
            m_state = M_PAID;
            exp_q.push_back(mk(m_paid, m_chg, 0, 1, 0));
        end
    endtask

    task automatic press(input logic [2:0] mask, input int width, input int gap, input bit eff);
        m_coin(mask, eff);
        coin1  = mask[0];
        coin5  = mask[1];
        coin10 = mask[2];
        tick(width);
        coin1  = 1'b0;
        coin5  = 1'b0;
        coin10 = 1'b0;
        tick(gap);
    endtask

    task automatic m_expire();
        if (m_state != M_COLLECT) return;
        m_chg   = m_paid;
        m_state = M_EXPIRED;
        exp_q.push_back(mk(m_paid, m_chg, 0, 0, 1));
    endtask

    task automatic do_ack();
        if (m_state == M_PAID || m_state == M_EXPIRED) begin
            exp_q.push_back(mk(m_paid, m_chg, 0, 0, 0));
            m_state = M_IDLE;
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    initial begin
        #500000;
        fails++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        int n;
        int last;
        int s;
        bit zero_seen;
        bit done;

        // Reset state
        tick(3);
        rst = 1'b0;
        check("reset_paid", {paidten, paidone}, 8'h00);
        check("reset_change", {changeten, changeone}, 8'h00);
        check("reset_secs", secsten * 10 + secsone, TOS);
        check("reset_flags", {busy, paid_ok, expired}, 0);
        prev_rec = rec();
        mon_en   = 1'b1;

        // Cost 25, coins 10,10,5 -> exact payment
        do_start(2, 5);
        press(3'b100, 6, 6, 1);
        press(3'b100, 6, 6, 1);
        press(3'b010, 6, 6, 1);
        drain(20);
        do_ack();
        drain(5);
        check("idle_after_ack_paid", paidten * 10 + paidone, 25);

        // Cost 07, coin10 -> change 03; latency of paid and flag; later coin ignored
        do_start(0, 7);
        drain(5);
        m_coin(3'b100, 1);
        coin10 = 1'b1;
        n = 0;
        while (n < 40 && {paidten, paidone} == 8'h00) begin
            @(negedge clk);
            n++;
        end
        check("coin_latency", n, 4 + DEB_LAT);
        @(negedge clk);
        check("flag_after_paid", {busy, paid_ok}, 2'b01);
        coin10 = 1'b0;
        tick(8);
        press(3'b010, 6, 6, 1);
        drain(10);
        check("ignored_coin_paid", paidten * 10 + paidone, 10);
        check("change_07", changeten * 10 + changeone, 3);
        do_ack();
        drain(5);

        // Cost 50, one coin5, let window run out; check countdown and refund
        do_start(5, 0);
        m_coin(3'b010, 1);
        m_expire();
        last = TOS; zero_seen = 0; done = 0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge clk);
            if (i == 0) coin5 = 1'b1;
            if (i == 6) coin5 = 1'b0;
            if (zero_seen) begin
                check("expire_after_00", expired, 1);
                done = 1;
            end else begin
                s = secsten * 10 + secsone;
                if (s != last) begin
                    check("secs_step", s, last - 1);
                    last = s;
                    if (s == 0) zero_seen = 1;
                end
            end
        end
        if (!done) check("expire_timeout", 0, 1);
        drain(20);
        do_ack();
        drain(5);

        // Cost 99, ten coin10 presses -> saturates at 99
        do_start(9, 9);
        for (int i = 0; i < 10; i++) press(3'b100, 6, 6, 1);
        drain(20);
        do_ack();
        drain(5);

        // Simultaneous coins from 00 -> 16; cost 16 pays exactly
        do_start(1, 6);
        press(3'b111, 6, 6, 1);
        drain(20);
        check("simultaneous_paid", paidten * 10 + paidone, 16);
        do_ack();
        drain(5);

        // Cost 00 -> PAID on the cycle after COLLECT entry
        do_start(0, 0);
        check("cost0_busy", busy, 1);
        @(negedge clk);
        check("cost0_paid_ok", paid_ok, 1);
        drain(5);
        do_ack();
        drain(5);

        // Reset mid-COLLECT with paid 15
        do_start(5, 0);
        press(3'b110, 6, 6, 1);
        drain(5);
        exp_q.push_back(mk(0, 0, 0, 0, 0));
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        m_state = M_IDLE; m_paid = 0; m_chg = 0;
        drain(5);
        check("rst_paid", {paidten, paidone}, 8'h00);
        check("rst_flags", {busy, paid_ok, expired}, 0);
        check("rst_secs", secsten * 10 + secsone, TOS);

        // Short glitch vs. a proper press on coin5, cost 10
        do_start(1, 0);
        press(3'b010, 3, 8, GLITCH_COUNTS);
        check("glitch_paid", paidten * 10 + paidone, GLITCH_COUNTS ? 5 : 0);
        press(3'b010, 6, 8, 1);
        check("press6_paid", paidten * 10 + paidone, GLITCH_COUNTS ? 10 : 5);
        press(3'b010, 6, 8, 1);
        drain(20);
        do_ack();
        drain(5);

        // Randomized transactions, including clamped cost digits and ignored start/ack
        for (int t = 0; t < 12; t++) begin
            int np;
            do_start($urandom_range(0, 15), $urandom_range(0, 15));
            np = $urandom_range(1, 15);
            for (int p = 0; p < np; p++) begin
                if ($urandom_range(0, 7) == 0) begin
                    start = 1'b1;
                    ack   = (m_state == M_COLLECT);
                    @(negedge clk);
                    start = 1'b0;
                    ack   = 1'b0;
                end
                press(3'($urandom_range(1, 7)), 6, 6, 1);
            end
            m_expire();
            drain(500);
            do_ack();
            drain(5);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
